axi_master_bridge: RTL and testbench
====================================

Name: axi_master_bridge

Overview: Parametrised AXI4 master front-end. Converts the beat-level user command interface (valid/ready, end_trans, master_error) into single-outstanding AXI4 bursts on the AW/W/B/AR/R channels. Sits between bench/user logic and the AXI interconnect. Adds write-data buffering, burst-length generation and response/protocol error reporting.

Parameters:
ADDR_WIDTH, 32, address bits.
DATA_WIDTH, 32, data bits; 32/64/128.
WBUF_DEPTH, 4, write-data FIFO entries; power of 2, >=2.

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
valid  in  1  user beat valid
ready  out  1  write: beat accepted; read: rdata valid pulse
cmd  in  ADDR_WIDTH+17  {write[1], prot[3], burst[2], size[3], len[8], addr}; sampled on first beat only
wdata  in  DATA_WIDTH  user write data
strb  in  DATA_WIDTH/8  user byte strobes
end_trans  in  1  user marks last beat
rdata  out  DATA_WIDTH  read data to user
master_error  out  1  one-cycle error pulse at transaction end
aw_payload  out  ADDR_WIDTH+16  {prot, burst, size, len, addr}
awvalid / awready  out / in  1  AW handshake
wdata_o  out  DATA_WIDTH  AXI write data
wstrb  out  DATA_WIDTH/8  AXI strobes
wlast  out  1  last W beat
wvalid / wready  out / in  1  W handshake
bresp  in  2  write response
bvalid / bready  in / out  1  B handshake
ar_payload  out  ADDR_WIDTH+16  same layout as aw_payload
arvalid / arready  out / in  1  AR handshake
rdata_i  in  DATA_WIDTH  AXI read data
rresp  in  2  read response
rlast  in  1  AXI last read beat
rvalid / rready  in / out  1  R handshake

Behaviour:
- Interface: one clock, clk; reset is rstn, asynchronous and active-low.
- Reset (also mid-transaction): all outputs 0; FSM to IDLE; WBUF flushed; beat counters 0.
- One transaction outstanding at a time. FSM: IDLE, WADDR (AW and W concurrent), WRESP, RADDR, RDATA.
- IDLE: on valid, latch cmd. Reject with no bus activity if size > log2(DATA_WIDTH/8) or burst==2'b11: master_error pulses the next cycle, stay IDLE. For writes, the rejected first beat is still accepted (ready=1).
- Write: ready = valid && WBUF not full && pushed <= len. awvalid rises the cycle after first-beat acceptance and holds until awready. W drains WBUF in order, independent of the AW handshake. wlast is set on beat len. Last W handshake moves to WRESP with bready=1; bvalid moves to IDLE.
- end_trans before beat len: remaining beats padded internally with strb=0. end_trans missing on beat len: beat sent, error flagged.
- Read: ready stays low during RADDR. arvalid is held until arready. RDATA: rready=1 constantly, no user backpressure. Each R beat drives rdata plus a one-cycle ready pulse. Return to IDLE on beat len.
- master_error pulses for one cycle at completion if any of: bresp[1] or rresp[1] set; end_trans mismatch; rlast not coincident with beat len.
- len is 8 bits; beat counter is 9 bits; no wrap.

Optional Feature:
AXI_MASTER_4K_CHECK_EN: when defined, reject in IDLE (master_error, no AW/AR) any INCR burst where addr[11:0] + ((len+1)<<size) > 4096, and any WRAP burst with len not in {1,3,7,15}. When undefined, these commands are forwarded unchanged.

Test Plan:
Single write addr 0x100, len 0, size 2, wdata 0xDEADBEEF, strb 0xF, bresp 0 -> aw_payload addr 0x100 len 0; one W beat with wlast=1; master_error stays 0.
INCR write len 3, wready low for 6 cycles, WBUF_DEPTH 4 -> all 4 beats accepted; W order 0..3; wlast on 4th beat only.
Read addr 0x2000, len 7, slave returns 0..7 -> arlen 7; 8 ready pulses with rdata 0..7; master_error 0.
Write with bresp=2'b10 -> master_error high for exactly 1 cycle after bvalid; FSM returns to IDLE.
DATA_WIDTH 32, size 3 -> master_error pulse; awvalid and arvalid never asserted.
INCR addr 0xFF8, size 2, len 3 -> macro defined: error, no AW; macro undefined: AW issued with addr 0xFF8.

Source files
------------

// File: rtl/axi_master_bridge_if.sv
// AXI4 channel bundle for axi_master_bridge: AW/W/B/AR/R signals with
// master (bridge) and slave (interconnect) views.
interface axi_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH+15:0]   aw_payload;
  logic                     awvalid, awready;
  logic [DATA_WIDTH-1:0]    wdata_o;
  logic [DATA_WIDTH/8-1:0]  wstrb;
  logic                     wlast, wvalid, wready;
  logic [1:0]               bresp;
  logic                     bvalid, bready;
  logic [ADDR_WIDTH+15:0]   ar_payload;
  logic                     arvalid, arready;
  logic [DATA_WIDTH-1:0]    rdata_i;
  logic [1:0]               rresp;
  logic                     rlast, rvalid, rready;

  modport master (
    output aw_payload, awvalid, wdata_o, wstrb, wlast, wvalid, bready,
           ar_payload, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata_i, rresp, rlast, rvalid
  );
  modport slave (
    input  aw_payload, awvalid, wdata_o, wstrb, wlast, wvalid, bready,
           ar_payload, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata_i, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_master_bridge.sv
// Beat-level user command port to single-outstanding AXI4 bursts, with write
// buffering and error reporting. Define AXI_MASTER_4K_CHECK_EN to reject 4KB-crossing INCR / bad-length WRAP bursts.
module axi_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid,
  output logic                     ready,
  input  logic [ADDR_WIDTH+16:0]   cmd,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  strb,
  input  logic                     end_trans,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     master_error,
  axi_master_bridge_if.master      axi
);
  localparam int SW    = ADDR_WIDTH + 16;
  localparam int BW    = DATA_WIDTH / 8;
  localparam int MAXSZ = $clog2(BW);
  localparam int PW    = $clog2(WBUF_DEPTH);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t                  state_q;
  logic [SW-1:0]           cmd_q;
  logic                    awvalid_q, arvalid_q, bready_q, rready_q;
  logic                    merr_q, rpulse_q, ended_q, err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [8:0]              pushed_q, popped_q, rbeat_q;
  logic [PW:0]             wr_ptr_q, rd_ptr_q;
  logic [BW+DATA_WIDTH-1:0] mem_q [WBUF_DEPTH];

  logic       c_wr, reject;
  logic [1:0] c_burst;
  logic [2:0] c_size;
  logic [7:0] c_len;
  logic [8:0] len9;
  logic [PW:0] fill;
  logic       full, empty, usr_beat, pad_beat, push, pop, wvalid;
  logic [BW+DATA_WIDTH-1:0] push_data, head;
  logic       unused;

  assign c_wr    = cmd[SW];
  assign c_burst = cmd[ADDR_WIDTH+11 +: 2];
  assign c_size  = cmd[ADDR_WIDTH+8 +: 3];
  assign c_len   = cmd[ADDR_WIDTH +: 8];
  assign len9    = {1'b0, cmd_q[ADDR_WIDTH +: 8]};
  assign unused  = ^{axi.bresp[0], axi.rresp[0]};

`ifdef AXI_MASTER_4K_CHECK_EN
  logic [16:0] span;
`endif

  always_comb begin
    reject = (c_size > 3'(MAXSZ)) || (c_burst == 2'b11);
`ifdef AXI_MASTER_4K_CHECK_EN
    span = 17'({1'b0, c_len} + 9'd1) << c_size;
    if (c_burst == 2'b01 && ({5'd0, cmd[11:0]} + span) > 17'd4096) reject = 1'b1;
    if (c_burst == 2'b10 && !(c_len inside {8'd1, 8'd3, 8'd7, 8'd15})) reject = 1'b1;
`endif
  end

  // Write buffer: user beats (or zero-strobe pads after an early end_trans) in, W beats out.
  assign fill      = wr_ptr_q - rd_ptr_q;
  assign full      = fill == (PW+1)'(WBUF_DEPTH);
  assign empty     = fill == '0;
  assign usr_beat  = valid && ((state_q == IDLE && c_wr) ||
                     (state_q == WADDR && !ended_q && !full && pushed_q <= len9));
  assign pad_beat  = state_q == WADDR && ended_q && !full && pushed_q <= len9;
  assign push      = (usr_beat && state_q != IDLE) || (usr_beat && !reject) || pad_beat;
  assign push_data = pad_beat ? '0 : {strb, wdata};
  assign wvalid    = state_q == WADDR && !empty;
  assign pop       = wvalid && axi.wready;
  assign head      = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

  assign ready          = (rstn && usr_beat) || rpulse_q;
  assign rdata          = rdata_q;
  assign master_error   = merr_q;
  assign axi.aw_payload = cmd_q;
  assign axi.ar_payload = cmd_q;
  assign axi.awvalid    = awvalid_q;
  assign axi.arvalid    = arvalid_q;
  assign axi.bready     = bready_q;
  assign axi.rready     = rready_q;
  assign axi.wvalid     = wvalid;
  assign axi.wdata_o    = wvalid ? head[DATA_WIDTH-1:0] : '0;
  assign axi.wstrb      = wvalid ? head[DATA_WIDTH +: BW] : '0;
  assign axi.wlast      = wvalid && popped_q == len9;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      merr_q    <= 1'b0;
      rpulse_q  <= 1'b0;
      ended_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      pushed_q  <= '0;
      popped_q  <= '0;
      rbeat_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      merr_q   <= 1'b0;
      rpulse_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (valid) begin
          cmd_q    <= cmd[SW-1:0];
          pushed_q <= '0;
          popped_q <= '0;
          rbeat_q  <= '0;
          ended_q  <= 1'b0;
          err_q    <= 1'b0;
          if (reject) merr_q <= 1'b1;
          else if (c_wr) begin
            state_q   <= WADDR;
            awvalid_q <= 1'b1;
            pushed_q  <= 9'd1;
            ended_q   <= end_trans && c_len != 8'd0;
            err_q     <= !end_trans && c_len == 8'd0;
          end else begin
            state_q   <= RADDR;
            arvalid_q <= 1'b1;
          end
        end
        WADDR: begin
          if (usr_beat) begin
            pushed_q <= pushed_q + 1'b1;
            if (pushed_q == len9) begin
              if (!end_trans) err_q <= 1'b1;
            end else if (end_trans) ended_q <= 1'b1;
          end
          if (pad_beat) pushed_q <= pushed_q + 1'b1;
          if (pop) begin
            popped_q <= popped_q + 1'b1;
            if (popped_q == len9) begin
              state_q  <= WRESP;
              bready_q <= 1'b1;
            end
          end
        end
        WRESP: if (axi.bvalid) begin
          bready_q <= 1'b0;
          state_q  <= IDLE;
          merr_q   <= err_q | axi.bresp[1];
        end
        RADDR: if (axi.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RDATA;
        end
        RDATA: if (axi.rvalid) begin
          rdata_q  <= axi.rdata_i;
          rpulse_q <= 1'b1;
          rbeat_q  <= rbeat_q + 1'b1;
          if (rbeat_q == len9) begin
            state_q  <= IDLE;
            rready_q <= 1'b0;
            merr_q   <= err_q | axi.rresp[1] | !axi.rlast;
          end else begin
            err_q <= err_q | axi.rresp[1] | axi.rlast;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: user-side and AXI slave stimulus driven
// linearly; passive monitors log W beats, AW/AR activity, read pulses and errors.
module tb_axi_master_bridge;
  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, ready, end_trans, master_error;
  logic [48:0] cmd;
  logic [31:0] wdata, rdata;
  logic [3:0]  strb;

  axi_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WBUF_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .valid(valid), .ready(ready), .cmd(cmd),
    .wdata(wdata), .strb(strb), .end_trans(end_trans), .rdata(rdata),
    .master_error(master_error), .axi(axi.master)
  );

  always #5 clk = ~clk;

  int vec = 0, miscmp = 0;
  int awv_cnt = 0, arv_cnt = 0, merr_cnt = 0;
  logic [47:0] aw_pl, ar_pl;
  logic [31:0] wq_d[$], rd_q[$];
  logic [3:0]  wq_s[$];
  logic        wq_l[$];

  always @(negedge clk) begin
    #2;
    if (rstn) begin
      if (axi.wvalid && axi.wready) begin
        wq_d.push_back(axi.wdata_o); wq_s.push_back(axi.wstrb); wq_l.push_back(axi.wlast);
      end
      if (axi.awvalid) begin awv_cnt++; if (axi.awready) aw_pl = axi.aw_payload; end
      if (axi.arvalid) begin arv_cnt++; if (axi.arready) ar_pl = axi.ar_payload; end
      if (master_error) merr_cnt++;
      if (ready && !valid) rd_q.push_back(rdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(); @(negedge clk); endtask
  task automatic idle(input int n); repeat (n) @(negedge clk); endtask

  task automatic clr();
    wq_d.delete(); wq_s.delete(); wq_l.delete(); rd_q.delete();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int last_user,
                          input logic et_ok, input int stall, input logic [1:0] br,
                          input logic [31:0] base, output int acc_cyc);
    int ub = 0, n = 0;
    logic b_pend = 1'b0, done = 1'b0;
    acc_cyc = -1;
    while (!done && n < 200) begin
      valid = (ub <= last_user);
      cmd   = {1'b1, 3'b000, 2'b01, 3'd2, len, addr};
      wdata = base + 32'(ub); strb = 4'hF;
      end_trans = et_ok && (ub == last_user);
      axi.wready = (n >= stall); axi.awready = 1'b1;
      axi.bvalid = b_pend; axi.bresp = br;
      #1;
      if (ready) begin ub++; if (ub == last_user + 1) acc_cyc = n; end
      if (axi.wvalid && axi.wready && axi.wlast) b_pend = 1'b1;
      if (axi.bvalid && axi.bready) done = 1'b1;
      cyc(); n++;
    end
    valid = 1'b0; end_trans = 1'b0; axi.bvalid = 1'b0; axi.wready = 1'b0;
    chk("wr_done", done, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int rlast_at,
                         input logic [1:0] rr);
    int beat = 0, n = 0;
    logic ar_done = 1'b0, ar_hs;
    while (beat <= int'(len) && n < 200) begin
      valid = (n == 0);
      cmd   = {1'b0, 3'b000, 2'b01, 3'd2, len, addr};
      axi.arready = 1'b1;
      axi.rvalid  = ar_done;
      axi.rdata_i = 32'(beat);
      axi.rlast   = (beat == rlast_at);
      axi.rresp   = rr;
      #1;
      ar_hs = axi.arvalid && axi.arready;
      if (axi.rvalid && axi.rready) beat++;
      if (ar_hs) ar_done = 1'b1;
      cyc(); n++;
    end
    valid = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.arready = 1'b0;
    chk("rd_done", beat, int'(len) + 1);
  endtask

  initial begin
    int acc, m0, a0, r0;
    rstn = 1'b0; valid = 1'b1; cmd = {1'b1, 3'b0, 2'b01, 3'd2, 8'd0, 32'h100};
    wdata = '0; strb = '0; end_trans = 1'b0;
    axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0; axi.arready = 0;
    axi.rdata_i = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
    idle(3); #1;
    chk("reset_ctl", {ready, axi.awvalid, axi.arvalid, axi.wvalid, axi.wlast,
                      axi.bready, axi.rready, master_error}, 8'h00);
    chk("reset_data", {rdata, axi.wdata_o}, 64'h0);
    chk("reset_payload", axi.aw_payload, 48'h0);
    valid = 1'b0; cyc(); rstn = 1'b1; idle(2);

    // single beat write
    clr(); m0 = merr_cnt;
    do_write(32'h100, 8'd0, 0, 1'b1, 0, 2'b00, 32'hDEADBEEF, acc);
    idle(2);
    chk("t1_aw_payload", aw_pl, {3'b0, 2'b01, 3'd2, 8'd0, 32'h100});
    chk("t1_wbeats", wq_d.size(), 1);
    chk("t1_w0", {wq_d[0], wq_s[0], 3'b0, wq_l[0]}, {32'hDEADBEEF, 4'hF, 4'h1});
    chk("t1_merr", merr_cnt - m0, 0);

    // INCR len 3 with W stalled: buffer absorbs all four beats
    clr(); m0 = merr_cnt;
    do_write(32'h200, 8'd3, 3, 1'b1, 6, 2'b00, 32'h0, acc);
    idle(2);
    chk("t2_accept_cycle", acc, 3);
    chk("t2_wbeats", wq_d.size(), 4);
    chk("t2_wdata", {wq_d[0][7:0], wq_d[1][7:0], wq_d[2][7:0], wq_d[3][7:0]}, 32'h00010203);
    chk("t2_wlast", {wq_l[0], wq_l[1], wq_l[2], wq_l[3]}, 4'b0001);
    chk("t2_merr", merr_cnt - m0, 0);

    // read burst of 8
    clr(); m0 = merr_cnt;
    do_read(32'h2000, 8'd7, 7, 2'b00);
    idle(3);
    chk("t3_ar_payload", ar_pl, {3'b0, 2'b01, 3'd2, 8'd7, 32'h2000});
    chk("t3_pulses", rd_q.size(), 8);
    chk("t3_rdata_first", rd_q[0], 32'd0);
    chk("t3_rdata_last", rd_q[7], 32'd7);
    chk("t3_rdata_mid", rd_q[4], 32'd4);
    chk("t3_merr", merr_cnt - m0, 0);

    // SLVERR on B: one-cycle pulse right after the B handshake
    clr(); m0 = merr_cnt;
    do_write(32'h300, 8'd0, 0, 1'b1, 0, 2'b10, 32'h1111, acc);
    #1;
    chk("t4_pulse_hi", {master_error, axi.bready}, 2'b10);
    cyc(); #1;
    chk("t4_pulse_lo", master_error, 1'b0);
    idle(2);
    chk("t4_merr_cnt", merr_cnt - m0, 1);

    // oversize write: beat taken, error, no AW
    m0 = merr_cnt; a0 = awv_cnt; r0 = arv_cnt;
    valid = 1'b1; cmd = {1'b1, 3'b0, 2'b01, 3'd3, 8'd0, 32'h400}; end_trans = 1'b1;
    #1; chk("t5_wr_ready", ready, 1'b1);
    cyc(); valid = 1'b0; end_trans = 1'b0; #1;
    chk("t5_wr_merr", master_error, 1'b1);
    // oversize read and reserved burst read
    cyc(); valid = 1'b1; cmd = {1'b0, 3'b0, 2'b01, 3'd3, 8'd0, 32'h400};
    #1; chk("t5_rd_ready", ready, 1'b0);
    cyc(); cmd = {1'b0, 3'b0, 2'b11, 3'd2, 8'd0, 32'h400};
    cyc(); valid = 1'b0; idle(3);
    chk("t5_merr_cnt", merr_cnt - m0, 3);
    chk("t5_no_addr", {awv_cnt - a0, arv_cnt - r0}, 64'h0);

    // INCR crossing 4KB
    clr(); m0 = merr_cnt; a0 = awv_cnt;
`ifdef AXI_MASTER_4K_CHECK_EN
    valid = 1'b1; cmd = {1'b1, 3'b0, 2'b01, 3'd2, 8'd3, 32'hFF8}; end_trans = 1'b0;
    axi.awready = 1'b1; axi.wready = 1'b1;
    cyc(); valid = 1'b0; idle(4);
    chk("t6_4k_merr", merr_cnt - m0, 1);
    chk("t6_4k_no_aw", awv_cnt - a0, 0);
`else
    do_write(32'hFF8, 8'd3, 3, 1'b1, 0, 2'b00, 32'h40, acc);
    idle(2);
    chk("t6_4k_aw_addr", aw_pl[31:0], 32'hFF8);
    chk("t6_4k_merr", merr_cnt - m0, 0);
`endif

    // early end_trans: remaining beats padded with strb 0
    clr(); m0 = merr_cnt;
    do_write(32'h500, 8'd2, 0, 1'b1, 0, 2'b00, 32'h55, acc);
    idle(2);
    chk("t7_wbeats", wq_d.size(), 3);
    chk("t7_beat0", {wq_d[0], wq_s[0], wq_l[0]}, {32'h55, 4'hF, 1'b0});
    chk("t7_pads", {wq_d[1], wq_s[1], wq_l[1], wq_d[2], wq_s[2], wq_l[2]},
                   {32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1});
    chk("t7_merr", merr_cnt - m0, 0);

    // end_trans missing on last beat
    m0 = merr_cnt;
    do_write(32'h600, 8'd1, 1, 1'b0, 0, 2'b00, 32'h66, acc);
    idle(2);
    chk("t8_no_end_merr", merr_cnt - m0, 1);

    // read error cases: SLVERR and missing rlast
    m0 = merr_cnt;
    do_read(32'h700, 8'd1, 1, 2'b10);
    idle(3);
    chk("t9_rresp_merr", merr_cnt - m0, 1);
    m0 = merr_cnt;
    do_read(32'h800, 8'd1, 99, 2'b00);
    idle(3);
    chk("t9_rlast_merr", merr_cnt - m0, 1);

    // reset mid-transaction, then a clean write sees a flushed buffer
    valid = 1'b1; cmd = {1'b1, 3'b0, 2'b01, 3'd2, 8'd3, 32'h900};
    wdata = 32'hBAD0; strb = 4'hF; end_trans = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    idle(2);
    rstn = 1'b0; #1;
    chk("t10_mid_reset", {ready, axi.awvalid, axi.wvalid, axi.bready, master_error}, 5'b0);
    valid = 1'b0; cyc(); rstn = 1'b1; cyc();
    clr(); m0 = merr_cnt;
    do_write(32'hA00, 8'd0, 0, 1'b1, 0, 2'b00, 32'h1234, acc);
    idle(2);
    chk("t10_flushed", {wq_d.size() == 1, wq_d[0]}, {1'b1, 32'h1234});
    chk("t10_merr", merr_cnt - m0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
